rf_write_arbiter: RTL and testbench
===================================

// Module: rf_write_arbiter
// PURPOSE
//  Owns the single register-file write port. Two requesters share it: A = in-order
//  pipeline writeback, B = long-latency unit (mul/div/load-miss). Priority is fixed
//  (A first) with starvation escape for B. Keeps a 32-entry busy scoreboard of
//  long-latency destinations and flags RAW/WAW hazards to the decode stall logic.
// PARAMETERS
//  STARVE_LIMIT  4   cycles B may wait while A wins before B is force-granted
//  CNT_W         3   width of starvation counter (>= clog2(STARVE_LIMIT+1))
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   reset, synchronous, active-low
//  a_valid     in   1   pipeline writeback request
//  a_addr      in   5   A destination register
//  a_data      in   32  A write data
//  a_ready     out  1   A accepted this cycle (comb); low => pipeline must hold
//  b_valid     in   1   long-latency result request
//  b_addr      in   5   B destination register
//  b_data      in   32  B write data
//  b_ready     out  1   B accepted this cycle (comb)
//  issue_valid in   1   long-latency op dispatched this cycle
//  issue_addr  in   5   its destination register
//  issue_stall out  1   comb: issue_valid & busy[issue_addr] & issue_addr!=0
//  rd_addr1    in   5   decode rs
//  rd_addr2    in   5   decode rt
//  hazard      out  2   comb: {rt busy, rs busy}; addr 0 never busy
//  reg_we      out  1   registered write enable to register file
//  write_addr  out  5   registered write address
//  write_data  out  32  registered write data
// BEHAVIOUR
//  - Reset (rst==0 at posedge): reg_we/write_addr/write_data=0, busy=0, wait_cnt=0;
//    any in-flight write or pending grant discarded. Comb outputs follow state.
//  - a_blk = busy[a_addr] & a_addr!=0 (WAW guard: A may not overtake pending B).
//  - starve = (wait_cnt == STARVE_LIMIT).
//  - Grant (comb, one per cycle):
//      b_ready = b_valid & (!a_valid | a_blk | starve)
//      a_ready = a_valid & !a_blk & !b_ready
//  - wait_cnt: +1 each cycle b_valid & !b_ready (saturate at STARVE_LIMIT);
//    cleared on b_ready or !b_valid.
//  - Latency 1: on grant, next posedge loads reg_we=1, write_addr/data = winner;
//    register file captures it on the following edge. No grant => reg_we=0.
//  - Address 0: handshake completes normally but reg_we stays 0.
//  - Scoreboard: issue_valid & !issue_stall & issue_addr!=0 sets busy[issue_addr].
//    busy[write_addr] clears at the edge where reg_we=1 from a B grant commits
//    (track source in a 1-bit out_src flag). Same-edge set and clear of same
//    address: set wins. Issue while issue_stall=1 is ignored (no state change).
//  - hazard bits stay set up to and including the cycle reg_we=1 for that address;
//    clear the cycle after (data visible in register file).
//  - b_valid for an address not busy is legal (written, no scoreboard effect).
// TESTING
//  1 Reset: rst=0 two cycles mid-write -> reg_we=0, hazard=00, busy all 0.
//  2 A only: a_valid, a_addr=5, a_data=32'h1234 -> a_ready=1; next cycle reg_we=1,
//    write_addr=5, write_data=32'h1234. a_addr=0 -> a_ready=1, reg_we stays 0.
//  3 Scoreboard: issue addr 7; rd_addr1=7 -> hazard=01; b_valid addr 7 granted;
//    hazard 01 through reg_we cycle, 00 the cycle after; re-issue 7 while busy ->
//    issue_stall=1, busy unchanged.
//  4 WAW: busy[9]=1, a_valid addr 9 -> a_ready=0; b_valid addr 9 -> b_ready=1
//    same cycle; A accepted two cycles later.
//  5 Starvation: a_valid continuous (distinct non-busy addrs), b_valid held ->
//    b_ready=0 for 4 cycles, 1 in 5th with a_ready=0; wait_cnt back to 0.
//  6 Set/clear race: B commit to addr 3 on same edge as issue to 3 -> busy[3]=1.

Source files
------------

// File: rtl/rf_write_arbiter_if.sv
// Register-file write arbiter handshake bundle: writeback requesters,
// long-latency issue, decode hazard query and the registered write port.
interface rf_write_arbiter_if;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        b_ready;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic        issue_stall;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic [1:0]  hazard;
    logic        reg_we;
    logic [4:0]  write_addr;
    logic [31:0] write_data;

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        output issue_valid, issue_addr,
        output rd_addr1, rd_addr2,
        input  a_ready, b_ready, issue_stall, hazard,
        input  reg_we, write_addr, write_data
    );

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        input  issue_valid, issue_addr,
        input  rd_addr1, rd_addr2,
        output a_ready, b_ready, issue_stall, hazard,
        output reg_we, write_addr, write_data
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Single register-file write port shared by pipeline writeback (A) and a
// long-latency unit (B), with a busy scoreboard for RAW/WAW hazards.
module rf_write_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input logic               clk,
    input logic               rst,
    rf_write_arbiter_if.slave bus
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [31:0]      busy_q, busy_d;
    logic             reg_we_q, reg_we_d;
    logic [4:0]       write_addr_q, write_addr_d;
    logic [31:0]      write_data_q, write_data_d;
    logic             out_src_q, out_src_d;

    logic a_blk, starve, a_rdy, b_rdy, stall;

    always_comb begin
        // A must not overtake an outstanding long-latency write (WAW)
        a_blk  = busy_q[bus.a_addr] & (bus.a_addr != 5'd0);
        starve = (wait_cnt_q == LIMIT);
        b_rdy  = bus.b_valid & (!bus.a_valid | a_blk | starve);
        a_rdy  = bus.a_valid & !a_blk & !b_rdy;
        stall  = bus.issue_valid & busy_q[bus.issue_addr]
               & (bus.issue_addr != 5'd0);
    end

    assign bus.a_ready     = a_rdy;
    assign bus.b_ready     = b_rdy;
    assign bus.issue_stall = stall;
    assign bus.hazard      = {
        busy_q[bus.rd_addr2] & (bus.rd_addr2 != 5'd0),
        busy_q[bus.rd_addr1] & (bus.rd_addr1 != 5'd0)
    };
    assign bus.reg_we      = reg_we_q;
    assign bus.write_addr  = write_addr_q;
    assign bus.write_data  = write_data_q;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!bus.b_valid || b_rdy) begin
            wait_cnt_d = '0;
        end else if (!starve) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end

        reg_we_d     = 1'b0;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        out_src_d    = out_src_q;
        if (b_rdy) begin
            reg_we_d     = (bus.b_addr != 5'd0);
            write_addr_d = bus.b_addr;
            write_data_d = bus.b_data;
            out_src_d    = 1'b1;
        end else if (a_rdy) begin
            reg_we_d     = (bus.a_addr != 5'd0);
            write_addr_d = bus.a_addr;
            write_data_d = bus.a_data;
            out_src_d    = 1'b0;
        end

        // clear first so a same-edge issue to the same register wins
        busy_d = busy_q;
        if (reg_we_q && out_src_q) begin
            busy_d[write_addr_q] = 1'b0;
        end
        if (bus.issue_valid && !stall && bus.issue_addr != 5'd0) begin
            busy_d[bus.issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt_q   <= '0;
            busy_q       <= '0;
            reg_we_q     <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            out_src_q    <= 1'b0;
        end else begin
            wait_cnt_q   <= wait_cnt_d;
            busy_q       <= busy_d;
            reg_we_q     <= reg_we_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            out_src_q    <= out_src_d;
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: reset, A path, scoreboard,
// WAW guard, starvation escape and set/clear race.
module tb_rf_write_arbiter;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    rf_write_arbiter_if bus();

    rf_write_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic any_busy;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst = 1'b0;
        bus.a_valid = 0; bus.a_addr = 0; bus.a_data = 0;
        bus.b_valid = 0; bus.b_addr = 0; bus.b_data = 0;
        bus.issue_valid = 0; bus.issue_addr = 0;
        bus.rd_addr1 = 0; bus.rd_addr2 = 0;
        step();
        step();
        rst = 1'b1;

        // 1: reset mid-write
        bus.issue_valid = 1; bus.issue_addr = 5'd12;
        bus.a_valid = 1; bus.a_addr = 5'd4; bus.a_data = 32'hAA;
        step();
        check("pre_rst_we", 32'(bus.reg_we), 32'd1);
        rst = 1'b0;
        bus.issue_valid = 0; bus.a_valid = 0;
        step();
        step();
        check("rst_we", 32'(bus.reg_we), 32'd0);
        check("rst_waddr", 32'(bus.write_addr), 32'd0);
        check("rst_wdata", bus.write_data, 32'd0);
        rst = 1'b1;
        any_busy = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.rd_addr1 = 5'(i);
            #1;
            any_busy = any_busy | bus.hazard[0];
        end
        check("rst_busy", 32'(any_busy), 32'd0);
        bus.rd_addr1 = 0;

        // 2: A only
        bus.a_valid = 1; bus.a_addr = 5'd5; bus.a_data = 32'h1234;
        #1;
        check("a_ready", 32'(bus.a_ready), 32'd1);
        step();
        bus.a_valid = 0;
        check("a_we", 32'(bus.reg_we), 32'd1);
        check("a_waddr", 32'(bus.write_addr), 32'd5);
        check("a_wdata", bus.write_data, 32'h1234);
        bus.a_valid = 1; bus.a_addr = 5'd0; bus.a_data = 32'h55;
        #1;
        check("a0_ready", 32'(bus.a_ready), 32'd1);
        step();
        bus.a_valid = 0;
        check("a0_we", 32'(bus.reg_we), 32'd0);

        // 3: scoreboard and hazard lifetime
        bus.issue_valid = 1; bus.issue_addr = 5'd7; bus.rd_addr1 = 5'd7;
        #1;
        check("iss7_stall", 32'(bus.issue_stall), 32'd0);
        step();
        bus.issue_valid = 0;
        #1;
        check("haz7_set", 32'(bus.hazard), 32'd1);
        bus.issue_valid = 1;
        #1;
        check("reiss7_stall", 32'(bus.issue_stall), 32'd1);
        step();
        bus.issue_valid = 0;
        #1;
        check("haz7_hold", 32'(bus.hazard), 32'd1);
        bus.b_valid = 1; bus.b_addr = 5'd7; bus.b_data = 32'hBEEF;
        #1;
        check("b7_ready", 32'(bus.b_ready), 32'd1);
        step();
        bus.b_valid = 0;
        #1;
        check("b7_we", 32'(bus.reg_we), 32'd1);
        check("b7_waddr", 32'(bus.write_addr), 32'd7);
        check("b7_wdata", bus.write_data, 32'hBEEF);
        check("haz7_wecyc", 32'(bus.hazard), 32'd1);
        step();
        check("haz7_clr", 32'(bus.hazard), 32'd0);
        bus.rd_addr1 = 0;

        // 4: WAW guard
        bus.issue_valid = 1; bus.issue_addr = 5'd9;
        step();
        bus.issue_valid = 0;
        bus.a_valid = 1; bus.a_addr = 5'd9; bus.a_data = 32'hA9;
        bus.b_valid = 1; bus.b_addr = 5'd9; bus.b_data = 32'hB9;
        #1;
        check("waw_a_blk", 32'(bus.a_ready), 32'd0);
        check("waw_b_rdy", 32'(bus.b_ready), 32'd1);
        step();
        bus.b_valid = 0;
        #1;
        check("waw_a_wait", 32'(bus.a_ready), 32'd0);
        check("waw_b_data", bus.write_data, 32'hB9);
        step();
        check("waw_a_go", 32'(bus.a_ready), 32'd1);
        step();
        bus.a_valid = 0;
        check("waw_a_addr", 32'(bus.write_addr), 32'd9);
        check("waw_a_data", bus.write_data, 32'hA9);

        // 5: starvation escape
        bus.b_valid = 1; bus.b_addr = 5'd20; bus.b_data = 32'hC0;
        for (int i = 0; i < 4; i++) begin
            bus.a_valid = 1; bus.a_addr = 5'(10 + i);
            bus.a_data = 32'(i);
            #1;
            check("stv_b_wait", 32'(bus.b_ready), 32'd0);
            check("stv_a_win", 32'(bus.a_ready), 32'd1);
            step();
        end
        bus.a_addr = 5'd14;
        #1;
        check("stv_b_force", 32'(bus.b_ready), 32'd1);
        check("stv_a_hold", 32'(bus.a_ready), 32'd0);
        step();
        check("stv_b_data", bus.write_data, 32'hC0);
        bus.b_data = 32'hC1;
        #1;
        check("stv_cnt_clr", 32'(bus.b_ready), 32'd0);
        step();
        bus.a_valid = 0; bus.b_valid = 0;
        step();

        // 6: same-edge clear/set race
        bus.b_valid = 1; bus.b_addr = 5'd3; bus.b_data = 32'h33;
        #1;
        check("race_b_rdy", 32'(bus.b_ready), 32'd1);
        step();
        bus.b_valid = 0;
        bus.issue_valid = 1; bus.issue_addr = 5'd3;
        #1;
        check("race_stall", 32'(bus.issue_stall), 32'd0);
        check("race_we", 32'(bus.reg_we), 32'd1);
        step();
        bus.issue_valid = 0;
        bus.rd_addr1 = 5'd3; bus.rd_addr2 = 5'd3;
        #1;
        check("race_busy", 32'(bus.hazard), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
